// File: rtl/m_lsu.sv
// m_lsu: M-stage load/store unit.
// Accepts one memory request at a time from the pipeline and drives it onto a
// req/ack data bus (DM plus two timers). It builds byte enables and replicated
// store data, extends load data, and reports address and bus-timeout errors.
// The pipeline is held through `stall` until the response pulse.
module m_lsu #(
  parameter logic [31:0] DM_BEGIN  = 32'h0000_0000,
  parameter logic [31:0] DM_END    = 32'h0000_2FFF,
  parameter logic [31:0] TC1_BEGIN = 32'h0000_7F00,
  parameter logic [31:0] TC1_END   = 32'h0000_7F0B,
  parameter logic [31:0] TC2_BEGIN = 32'h0000_7F10,
  parameter logic [31:0] TC2_END   = 32'h0000_7F1B,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ov,
  input  logic        flush,
  output logic        req_ready,
  output logic        stall,
  output logic        m_data_req,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic        m_data_ack,
  input  logic [31:0] m_data_rdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Operation codes
  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  // Wait counter: wide enough for TIMEOUT-1, which is where it stops
  localparam int unsigned    CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  // State and registered outputs
  logic [1:0]    r_state;
  logic [3:0]    r_op;
  logic [1:0]    r_off;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_byteen;
  logic          r_resp_valid;
  logic [31:0]   r_rdata;
  logic          r_adel;
  logic          r_ades;
  logic          r_bus;

  // Request decode
  logic        w_is_load;
  logic        w_is_store;
  logic        w_valid_op;
  logic        w_in_dm;
  logic        w_in_tc1;
  logic        w_in_tc2;
  logic        w_in_tc;
  logic        w_misalign;
  logic        w_timer_bad;
  logic        w_cnt_reg;
  logic        w_err;
  logic [3:0]  w_byteen;
  logic [31:0] w_wdata;

  // Load extension
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Classify the live request and evaluate address errors
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: w_is_load  = 1'b1;
      OP_SW, OP_SH, OP_SB:                 w_is_store = 1'b1;
      default: ;
    endcase
    w_valid_op = w_is_load | w_is_store;

    // Offset-from-base compares avoid always-true checks when a base is zero
    w_in_dm  = ((addr - DM_BEGIN)  <= (DM_END  - DM_BEGIN));
    w_in_tc1 = ((addr - TC1_BEGIN) <= (TC1_END - TC1_BEGIN));
    w_in_tc2 = ((addr - TC2_BEGIN) <= (TC2_END - TC2_BEGIN));
    w_in_tc  = w_in_tc1 | w_in_tc2;

    w_misalign = 1'b0;
    case (op)
      OP_LW, OP_SW:         w_misalign = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: w_misalign = addr[0];
      default: ;
    endcase

    // Timers only accept full-word accesses; their count register is read-only
    w_timer_bad = w_in_tc && (op != OP_LW) && (op != OP_SW);
    w_cnt_reg   = w_is_store &&
                  (((addr - TC1_BEGIN) == 32'd8) || ((addr - TC2_BEGIN) == 32'd8));

    w_err = w_misalign | ~(w_in_dm | w_in_tc) | w_timer_bad | ov | w_cnt_reg;
  end

  // Byte enables and lane-replicated store data for the live request
  always_comb begin
    w_byteen = '0;
    w_wdata  = '0;
    case (op)
      OP_SW: begin
        w_byteen = 4'b1111;
        w_wdata  = wdata;
      end
      OP_SH: begin
        w_byteen = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata  = {2{wdata[15:0]}};
      end
      OP_SB: begin
        w_byteen = 4'b0001 << addr[1:0];
        w_wdata  = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Select and extend the returned word using the op/offset latched at accept
  always_comb begin
    case (r_off)
      2'd0:    w_byte = m_data_rdata[7:0];
      2'd1:    w_byte = m_data_rdata[15:8];
      2'd2:    w_byte = m_data_rdata[23:16];
      default: w_byte = m_data_rdata[31:24];
    endcase
    w_half = r_off[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];

    w_ext = '0;
    case (r_op)
      OP_LW:  w_ext = m_data_rdata;
      OP_LH:  w_ext = {{16{w_half[15]}}, w_half};
      OP_LHU: w_ext = {16'h0000, w_half};
      OP_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU: w_ext = {24'h00_0000, w_byte};
      default: ;
    endcase
  end

  // Control FSM with registered bus and response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_off        <= '0;
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_byteen     <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_adel       <= 1'b0;
      r_ades       <= 1'b0;
      r_bus        <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (flush) begin
        // Abort whatever is in flight; any pending response is dropped
        r_state <= S_IDLE;
        r_req   <= 1'b0;
        r_adel  <= 1'b0;
        r_ades  <= 1'b0;
        r_bus   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req_valid && w_valid_op) begin
              if (w_err) begin
                r_adel       <= w_is_load;
                r_ades       <= w_is_store;
                r_rdata      <= '0;
                r_resp_valid <= 1'b1;
                r_state      <= S_DONE;
              end else begin
                r_addr   <= {addr[31:2], 2'b00};
                r_byteen <= w_byteen;
                r_wdata  <= w_wdata;
                r_op     <= op;
                r_off    <= addr[1:0];
                r_cnt    <= '0;
                r_req    <= 1'b1;
                r_state  <= S_BUS;
              end
            end
          end
          S_BUS: begin
            if (m_data_ack) begin
              r_rdata      <= w_ext;
              r_req        <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
            end else if (r_cnt == CNT_LAST) begin
              r_bus        <= 1'b1;
              r_rdata      <= '0;
              r_req        <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DONE: begin
            r_adel  <= 1'b0;
            r_ades  <= 1'b0;
            r_bus   <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign stall         = req_valid && w_valid_op && (r_state != S_DONE);
  assign m_data_req    = r_req;
  assign m_data_addr   = r_addr;
  assign m_data_wdata  = r_wdata;
  assign m_data_byteen = r_byteen;
  assign resp_valid    = r_resp_valid;
  assign rdata         = r_rdata;
  assign exc_adel      = r_adel;
  assign exc_ades      = r_ades;
  assign exc_bus       = r_bus;

endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: directed-vector bench for m_lsu with hand-computed expectations.
module tb_m_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ov;
  logic        flush;
  logic        req_ready;
  logic        stall;
  logic        m_data_req;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic        m_data_ack;
  logic [31:0] m_data_rdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_bus;

  int unsigned n_vec;
  int unsigned n_err;

  // Observations from the last transaction
  int unsigned obs_lat;
  int unsigned obs_req_cnt;
  int unsigned obs_stall_cnt;
  logic [31:0] obs_addr;
  logic [31:0] obs_wd;
  logic [3:0]  obs_be;

  m_lsu #(.TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .op            (op),
    .addr          (addr),
    .wdata         (wdata),
    .ov            (ov),
    .flush         (flush),
    .req_ready     (req_ready),
    .stall         (stall),
    .m_data_req    (m_data_req),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_ack    (m_data_ack),
    .m_data_rdata  (m_data_rdata),
    .resp_valid    (resp_valid),
    .rdata         (rdata),
    .exc_adel      (exc_adel),
    .exc_ades      (exc_ades),
    .exc_bus       (exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request, ack it in bus cycle t_ack (0 = never), return at the
  // response cycle (or after a cycle budget) with observations recorded.
  task automatic txn(input logic [3:0] t_op, input logic [31:0] t_addr,
                     input logic [31:0] t_wd, input logic t_ov,
                     input int unsigned t_ack, input logic [31:0] t_rd);
    req_valid = 1'b1;
    op        = t_op;
    addr      = t_addr;
    wdata     = t_wd;
    ov        = t_ov;
    obs_req_cnt   = 0;
    obs_stall_cnt = 0;
    #1;
    if (stall) obs_stall_cnt++;
    tick();
    obs_lat  = 1;
    obs_addr = m_data_addr;
    obs_wd   = m_data_wdata;
    obs_be   = m_data_byteen;
    while (obs_lat < 64) begin
      if (m_data_req) obs_req_cnt++;
      if (resp_valid) break;
      if (stall) obs_stall_cnt++;
      if (obs_lat == t_ack) begin
        m_data_ack   = 1'b1;
        m_data_rdata = t_rd;
      end
      tick();
      m_data_ack = 1'b0;
      obs_lat++;
    end
  endtask

  task automatic release_req();
    req_valid = 1'b0;
    op        = 4'd0;
    ov        = 1'b0;
    tick();
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } ext_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic        ov;
    logic        adel;
    logic        ades;
  } err_t;

  ext_t ext_tab [0:8];
  err_t err_tab [0:5];
  int unsigned seen;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    req_valid = 1'b0;
    op = '0;
    addr = '0;
    wdata = '0;
    ov = 1'b0;
    flush = 1'b0;
    m_data_ack = 1'b0;
    m_data_rdata = '0;

    // op, addr, wdata, rdata, expected rdata, byteen, bus wdata
    ext_tab[0] = '{4'd4, 32'h0000_0103, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80, 4'b0000, 32'h0};
    ext_tab[1] = '{4'd5, 32'h0000_0103, 32'h0, 32'h80FF_1234, 32'h0000_0080, 4'b0000, 32'h0};
    ext_tab[2] = '{4'd2, 32'h0000_0102, 32'h0, 32'h80FF_1234, 32'hFFFF_80FF, 4'b0000, 32'h0};
    ext_tab[3] = '{4'd3, 32'h0000_0100, 32'h0, 32'h80FF_9234, 32'h0000_9234, 4'b0000, 32'h0};
    ext_tab[4] = '{4'd4, 32'h0000_0101, 32'h0, 32'h80FF_1234, 32'h0000_0012, 4'b0000, 32'h0};
    ext_tab[5] = '{4'd1, 32'h0000_7F04, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 32'h0};
    ext_tab[6] = '{4'd7, 32'h0000_0012, 32'hABCD_5678, 32'hFFFF_FFFF, 32'h0, 4'b1100, 32'h5678_5678};
    ext_tab[7] = '{4'd8, 32'h0000_2001, 32'h1234_56AB, 32'hFFFF_FFFF, 32'h0, 4'b0010, 32'hABAB_ABAB};
    ext_tab[8] = '{4'd6, 32'h0000_2FFC, 32'h1122_3344, 32'hFFFF_FFFF, 32'h0, 4'b1111, 32'h1122_3344};

    err_tab[0] = '{4'd1, 32'h0000_0002, 1'b0, 1'b1, 1'b0};
    err_tab[1] = '{4'd2, 32'h0000_7F00, 1'b0, 1'b1, 1'b0};
    err_tab[2] = '{4'd6, 32'h0000_7F08, 1'b0, 1'b0, 1'b1};
    err_tab[3] = '{4'd1, 32'h0000_3000, 1'b0, 1'b1, 1'b0};
    err_tab[4] = '{4'd1, 32'h0000_0010, 1'b1, 1'b1, 1'b0};
    err_tab[5] = '{4'd8, 32'h0000_7F01, 1'b0, 1'b0, 1'b1};

    // Reset state
    #2;
    check("rst_req", {31'b0, m_data_req}, 32'h0);
    check("rst_resp", {31'b0, resp_valid}, 32'h0);
    check("rst_exc", {29'b0, exc_adel, exc_ades, exc_bus}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_ready", {31'b0, req_ready}, 32'h1);

    // op none / reserved op: no stall, no accept
    req_valid = 1'b1;
    op = 4'd0;
    addr = 32'h0000_0100;
    #1;
    check("none_stall", {31'b0, stall}, 32'h0);
    op = 4'd9;
    #1;
    check("op9_stall", {31'b0, stall}, 32'h0);
    tick();
    check("op9_idle", {30'b0, req_ready, m_data_req}, 32'h2);
    release_req();

    // lb with ack in the third bus cycle
    txn(4'd4, 32'h0000_0103, 32'h0, 1'b0, 3, 32'h80FF_1234);
    check("lb_lat", obs_lat, 32'd4);
    check("lb_addr", obs_addr, 32'h0000_0100);
    check("lb_be", {28'b0, obs_be}, 32'h0);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    check("lb_stall_cycles", obs_stall_cnt, 32'd4);
    check("lb_stall_done", {31'b0, stall}, 32'h0);
    check("lb_exc", {29'b0, exc_adel, exc_ades, exc_bus}, 32'h0);
    release_req();
    check("lb_pulse", {30'b0, resp_valid, req_ready}, 32'h1);

    // Extension / byte-enable / store-data table, immediate ack
    for (int unsigned i = 0; i < 9; i++) begin
      txn(ext_tab[i].op, ext_tab[i].addr, ext_tab[i].wd, 1'b0, 1, ext_tab[i].rd);
      check($sformatf("ext%0d_lat", i), obs_lat, 32'd2);
      check($sformatf("ext%0d_addr", i), obs_addr, {ext_tab[i].addr[31:2], 2'b00});
      check($sformatf("ext%0d_be", i), {28'b0, obs_be}, {28'b0, ext_tab[i].exp_be});
      if (ext_tab[i].op >= 4'd6)
        check($sformatf("ext%0d_wd", i), obs_wd, ext_tab[i].exp_wd);
      check($sformatf("ext%0d_rdata", i), rdata, ext_tab[i].exp_rd);
      check($sformatf("ext%0d_exc", i), {29'b0, exc_adel, exc_ades, exc_bus}, 32'h0);
      release_req();
    end

    // Address errors: response one cycle after accept, no bus request
    for (int unsigned i = 0; i < 6; i++) begin
      txn(err_tab[i].op, err_tab[i].addr, 32'h5555_AAAA, err_tab[i].ov, 1, 32'h0);
      check($sformatf("err%0d_lat", i), obs_lat, 32'd1);
      check($sformatf("err%0d_req", i), obs_req_cnt, 32'd0);
      check($sformatf("err%0d_exc", i), {29'b0, exc_adel, exc_ades, exc_bus},
            {29'b0, err_tab[i].adel, err_tab[i].ades, 1'b0});
      check($sformatf("err%0d_rdata", i), rdata, 32'h0);
      release_req();
      check($sformatf("err%0d_clr", i), {29'b0, exc_adel, exc_ades, exc_bus}, 32'h0);
    end

    // Bus timeout on lhu
    txn(4'd3, 32'h0000_0002, 32'h0, 1'b0, 0, 32'h0);
    check("to_req_cycles", obs_req_cnt, 32'd16);
    check("to_lat", obs_lat, 32'd17);
    check("to_resp", {31'b0, resp_valid}, 32'h1);
    check("to_exc", {29'b0, exc_adel, exc_ades, exc_bus}, 32'h1);
    check("to_rdata", rdata, 32'h0);
    release_req();

    // Flush in the second bus cycle of a lw
    req_valid = 1'b1;
    op = 4'd1;
    addr = 32'h0000_0040;
    tick();
    check("fl_req1", {31'b0, m_data_req}, 32'h1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    op = 4'd0;
    check("fl_req_off", {31'b0, m_data_req}, 32'h0);
    check("fl_ready", {31'b0, req_ready}, 32'h1);
    seen = {31'b0, resp_valid};
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    check("fl_no_resp", seen, 32'd0);

    // Asynchronous reset in the middle of a bus transaction
    req_valid = 1'b1;
    op = 4'd1;
    addr = 32'h0000_0044;
    tick();
    check("ar_req_pre", {31'b0, m_data_req}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req", {31'b0, m_data_req}, 32'h0);
    check("ar_addr", m_data_addr, 32'h0);
    check("ar_resp", {31'b0, resp_valid}, 32'h0);
    req_valid = 1'b0;
    op = 4'd0;
    tick();
    reset = 1'b1;
    #1;
    check("ar_ready", {31'b0, req_ready}, 32'h1);
    tick();
    txn(4'd1, 32'h0000_0008, 32'h0, 1'b0, 1, 32'h1234_5678);
    check("ar_lw_lat", obs_lat, 32'd2);
    check("ar_lw_rdata", rdata, 32'h1234_5678);
    release_req();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/m_lsu.md
# m_lsu

Multi-cycle load/store unit for the M stage of the pipelined CPU. It sits between the M-stage pipeline register and the external data bus (DM plus two timers). It issues one memory transaction per accepted request over a req/ack handshake with variable latency. It also generates byte enables and store-data replication, sign- or zero-extends load data, and raises AdEL/AdES/bus-timeout exceptions, stalling the pipeline until the response is delivered.

## Interface
- `DM_BEGIN`, 32'h0000_0000, first DM byte address
- `DM_END`, 32'h0000_2FFF, last DM byte address
- `TC1_BEGIN`, 32'h0000_7F00, timer 1 base; `TC1_END`, 32'h0000_7F0B
- `TC2_BEGIN`, 32'h0000_7F10, timer 2 base; `TC2_END`, 32'h0000_7F1B
- `TIMEOUT`, 16, bus cycles to wait for `m_data_ack` before a bus error (≥2)
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `req_valid` in 1: M-stage memory operation present; held stable until `resp_valid`
- `op` in 4: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9–15 treated as none
- `addr` in 32: effective byte address
- `wdata` in 32: store data, right-aligned
- `ov` in 1: address-add overflow from ALU
- `flush` in 1: CP0 exception/eret flush; aborts the current operation
- `req_ready` out 1: unit idle, can accept
- `stall` out 1: hold the pipeline
- `m_data_req` out 1, `m_data_addr` out 32, `m_data_wdata` out 32, `m_data_byteen` out 4 (all-zero for loads)
- `m_data_ack` in 1, `m_data_rdata` in 32: bus completion and read word
- `resp_valid` out 1: one-cycle completion pulse
- `rdata` out 32: extended load result, valid with `resp_valid`
- `exc_adel`, `exc_ades`, `exc_bus` out 1 each: valid with `resp_valid`

## Operation
- FSM states are IDLE, BUS and DONE. `req_ready` = (state==IDLE).
- **IDLE**, on `req_valid` & op≠none & !`flush`:
  - The unit evaluates errors from the live inputs.
  - With an error it latches the exception flags and goes to DONE without asserting `m_data_req`.
  - Without an error it registers `m_data_addr` = {addr[31:2],2'b00}, byteen, replicated wdata and op, clears the wait counter, and goes to BUS.
- An op=none request is ignored and the unit stays in IDLE.
- Load error (AdEL) when any of the following holds:
  - lw with addr[1:0]≠0;
  - lh/lhu with addr[0]≠0;
  - addr outside all three ranges;
  - a non-lw access inside a timer range;
  - `ov`.
- Store error (AdES) uses the same conditions as AdEL, plus a store to offset 8 (count register) of either timer.
- Byte enables:
  - sw gives 4'b1111.
  - sh gives addr[1] ? 4'b1100 : 4'b0011.
  - sb gives 4'b0001<<addr[1:0].
- Store data: sh puts {2{wdata[15:0]}} on the bus and sb puts {4{wdata[7:0]}}.
- **BUS**:
  - `m_data_req` is 1 and all bus outputs are constant.
  - On `m_data_ack` the unit captures the extended `m_data_rdata` and goes to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT−1 with no ack, the unit sets `exc_bus` and goes to DONE. The counter is $clog2(TIMEOUT) bits wide and never wraps.
- Load extension, selected by addr[1:0] registered at accept:
  - lb/lbu take byte addr[1:0]; lh/lhu take half addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - lw passes the word through.
  - Stores and error cases give `rdata`=0.
- **DONE**: `resp_valid`=1 for exactly one cycle, then IDLE. The exception flags are mutually exclusive and are cleared on the IDLE transition.
- `stall` = `req_valid` & op≠none & (state≠DONE).
- `flush` in any state sends the unit to IDLE on the next edge. It suppresses that cycle's `resp_valid` and the pending exception flags, and deasserts `m_data_req` from the next cycle. If ack and flush arrive together, flush wins and the read data is discarded. A store acked in that cycle is still committed by the bus.
- Reset (asynchronous, any state):
  - state goes to IDLE;
  - `m_data_req`, `m_data_addr`, `m_data_wdata`, `m_data_byteen`, `resp_valid`, `rdata` and all exception flags go to 0;
  - `req_ready`=1 once reset is released.

## Timing
- The request is accepted at edge t, so BUS is entered at t+1.
- An ack sampled in BUS cycle k gives `resp_valid` in cycle k+1. The minimum is 2 cycles accept-to-response.
- An error request gives `resp_valid` 1 cycle after accept, with no bus activity.
- Timeout: with no ack, `m_data_req` stays high for TIMEOUT cycles and `resp_valid`+`exc_bus` follow in the next cycle.
- Back-to-back: the earliest next accept is the cycle after DONE (one IDLE cycle between operations).
- All outputs are registered except `req_ready` and `stall`.

## Test plan
- lb at 0x0000_0103 with rdata 0x80FF_1234, ack after 3 bus cycles → byteen 0000, `rdata`=0xFFFF_FF80, `resp_valid` 4 cycles after accept, `stall` high until then.
- sh at 0x0000_0012 with wdata 0xABCD_5678 → `m_data_addr`=0x10, byteen 1100, `m_data_wdata`=0x5678_5678, `exc_ades`=0.
- Each of the following gives the stated exception with `resp_valid` 1 cycle after accept and `m_data_req` never high:
  - lw 0x0000_0002 → `exc_adel`;
  - lh at 0x0000_7F00 → `exc_adel`;
  - sw at 0x0000_7F08 → `exc_ades`;
  - lw at 0x0000_3000 → `exc_adel`.
- lhu at 0x0000_0002 with no ack and TIMEOUT=16 → `m_data_req` high for 16 cycles, then `exc_bus`=1 and `rdata`=0.
- lw in BUS with `flush` in the 2nd bus cycle → `m_data_req` low the next cycle, no `resp_valid`, `req_ready`=1.
- `reset` low mid-BUS → all outputs 0 immediately. After release, a new lw with immediate ack completes in 2 cycles.
